i2c_master_ctrl: RTL and testbench

Single-byte I2C bus master that sequences complete transactions against the `i2c_slave` datapath: START, 7-bit address plus R/W, slave ACK check, one data byte written or read, acknowledge, STOP. It sits between the system-side request interface and the open-drain SCL/SDA pads. It also serves as the synthesizable replacement for hand-timed bench stimulus.

---
 rtl/i2c_master_ctrl.sv | 168 ++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C bus master: START, {ADDR,RW}, ACK check, one data byte, ACK, STOP.
// Every bus phase is built from quarters of CLK_DIV cycles; SCL and SDA_OE are registered.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enb,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [2:0] dbg_state
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, STRT, ADDR, ACKA, DATA, ACKD, STOP} state_t;

    state_t        state, state_d;
    logic [QW-1:0] qcnt, qcnt_d;
    logic [1:0]    quarter, quarter_d;
    logic [2:0]    bitcnt, bitcnt_d;
    logic [7:0]    shift, shift_d, wbyte, wbyte_d, rdata_d;
    logic          rw_q, rw_d, sample, sample_d;
    logic          nack_d, done_d, busy_d, scl_d, sda_oe_d;
    logic          q_end, slot_end;

    assign q_end     = (qcnt == QMAX);
    assign slot_end  = q_end && (quarter == 2'd3);
    assign dbg_state = state;

    // Request handshake: start acts as valid, ~busy as ready; a request is taken only
    // on a cycle where start=1, enb=1 and the controller is idle, and operands are
    // latched on that cycle only.
    always_comb begin
        state_d   = state;
        qcnt_d    = q_end ? '0 : qcnt + QW'(1);
        quarter_d = q_end ? quarter + 2'd1 : quarter;
        bitcnt_d  = bitcnt;
        shift_d   = shift;
        wbyte_d   = wbyte;
        rw_d      = rw_q;
        sample_d  = sample;
        rdata_d   = rdata;
        nack_d    = nack;
        done_d    = 1'b0;

        if (state != IDLE && q_end && quarter == 2'd2)
            sample_d = sda_in;

        case (state)
            IDLE: begin
                qcnt_d    = '0;
                quarter_d = 2'd0;
                bitcnt_d  = 3'd0;
                if (enb && start) begin
                    state_d = STRT;
                    shift_d = {addr, rw};
                    wbyte_d = wdata;
                    rw_d    = rw;
                    nack_d  = 1'b0;
                end
            end
            STRT: if (slot_end) state_d = ADDR;
            ADDR: if (slot_end) begin
                shift_d  = {shift[6:0], 1'b0};
                bitcnt_d = bitcnt + 3'd1;
                if (bitcnt == 3'd7) state_d = ACKA;
            end
            ACKA: if (slot_end) begin
                if (sample) begin
                    nack_d  = 1'b1;
                    state_d = STOP;
                end else begin
                    state_d = DATA;
                    shift_d = wbyte;
                end
            end
            // Shifting the sample in on writes is harmless: those bits are never read.
            DATA: if (slot_end) begin
                shift_d  = {shift[6:0], sample};
                bitcnt_d = bitcnt + 3'd1;
                if (bitcnt == 3'd7) state_d = ACKD;
            end
            ACKD: if (slot_end) begin
                state_d = STOP;
                if (rw_q) rdata_d = shift;
                else if (sample) nack_d = 1'b1;
            end
            STOP: if (slot_end) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Losing enable mid-transaction still ends the bus cleanly with a STOP.
        if (state != IDLE && state != STOP && !enb && q_end) begin
            state_d   = STOP;
            quarter_d = 2'd0;
            nack_d    = 1'b1;
            rdata_d   = rdata;
        end

        busy_d   = (state_d != IDLE);
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            STRT: sda_oe_d = quarter_d[1];
            ADDR: begin
                scl_d    = quarter_d[1];
                sda_oe_d = ~shift_d[7];
            end
            DATA: begin
                scl_d    = quarter_d[1];
                sda_oe_d = ~rw_d & ~shift_d[7];
            end
            ACKA, ACKD: scl_d = quarter_d[1];
            STOP: begin
                scl_d    = (quarter_d != 2'd0);
                sda_oe_d = ~quarter_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            qcnt    <= '0;
            quarter <= 2'd0;
            bitcnt  <= 3'd0;
            shift   <= 8'h00;
            wbyte   <= 8'h00;
            rw_q    <= 1'b0;
            sample  <= 1'b1;
            rdata   <= 8'h00;
            nack    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            scl     <= 1'b1;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_d;
            qcnt    <= qcnt_d;
            quarter <= quarter_d;
            bitcnt  <= bitcnt_d;
            shift   <= shift_d;
            wbyte   <= wbyte_d;
            rw_q    <= rw_d;
            sample  <= sample_d;
            rdata   <= rdata_d;
            nack    <= nack_d;
            done    <= done_d;
            busy    <= busy_d;
            scl     <= scl_d;
            sda_oe  <= sda_oe_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level slave/monitor, vector table, random transactions
// against a transaction-level model, and hand-written abort/reset/restart sequences.
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enb = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       scl, sda_oe, busy, done, nack, sda_bus;
    logic [7:0] rdata;
    logic [2:0] dbg_state;

    logic       slave_low = 1'b0;
    logic       cfg_aa = 1'b1, cfg_ad = 1'b1;
    logic [7:0] cfg_rb = 8'h00;
    logic       prev_scl = 1'b1, prev_bus = 1'b1, in_txn = 1'b0, sl_rd = 1'b0;
    logic       rd_ack_oe = 1'b0;
    int         bit_idx = -1;
    int         stop_cnt = 0, done_cnt = 0;
    logic       mon_bits[$];
    logic [8:0] exp_q[$];
    logic [7:0] model_rdata = 8'h00;
    int         n_vec = 0, n_err = 0;

    assign sda_bus = ~(sda_oe | slave_low);

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .enb(enb), .start(start), .rw(rw),
        .addr(addr), .wdata(wdata), .sda_in(sda_bus), .scl(scl), .sda_oe(sda_oe),
        .rdata(rdata), .busy(busy), .done(done), .nack(nack), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- bus-level slave and monitor ----------------
    function automatic logic slave_drive(input int idx);
        if (idx == 8) return cfg_aa;
        if (idx >= 9 && idx <= 16) return cfg_aa && sl_rd && !cfg_rb[16-idx];
        if (idx == 17) return cfg_aa && !sl_rd && cfg_ad;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_scl  <= 1'b1;
            prev_bus  <= 1'b1;
            in_txn    <= 1'b0;
            bit_idx   <= -1;
            slave_low <= 1'b0;
        end else begin
            prev_scl <= scl;
            prev_bus <= sda_bus;
            if (done) done_cnt <= done_cnt + 1;
            if (in_txn && sl_rd && bit_idx == 17 && !(prev_scl && !scl) && sda_oe)
                rd_ack_oe <= 1'b1;
            if (prev_scl && scl && prev_bus && !sda_bus) begin
                in_txn  <= 1'b1;
                bit_idx <= -1;
                sl_rd   <= 1'b0;
                mon_bits.delete();
            end else if (prev_scl && scl && !prev_bus && sda_bus) begin
                // STOP: drop the bit clocked during the STOP's own SCL rise
                in_txn   <= 1'b0;
                stop_cnt <= stop_cnt + 1;
                if (mon_bits.size() > 0) mon_bits.pop_back();
            end else if (in_txn && !prev_scl && scl) begin
                mon_bits.push_back(sda_bus);
                if (bit_idx == 7) sl_rd <= sda_bus;
            end else if (in_txn && prev_scl && !scl) begin
                bit_idx   <= bit_idx + 1;
                slave_low <= slave_drive(bit_idx + 1);
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_frames(input string name);
        int nf;
        logic [8:0] got;
        nf = exp_q.size();
        check({name, "_nbits"}, 32'(mon_bits.size()), 32'(9 * nf));
        for (int i = 0; i < nf; i++) begin
            got = '0;
            for (int b = 0; b < 9; b++)
                if (9 * i + b < mon_bits.size()) got = {got[7:0], mon_bits[9*i+b]};
            check({name, "_frame"}, 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic wait_done(input int limit, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] w,
                          input logic aa, input logic ad, input logic [7:0] rb);
        @(negedge clk);
        cfg_aa = aa; cfg_ad = ad; cfg_rb = rb;
        addr = a; rw = r; wdata = w; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic txn(input string name, input logic [6:0] a, input logic r,
                       input logic [7:0] w, input logic aa, input logic ad,
                       input logic [7:0] rb, input int exp_qtr, input logic exp_nack,
                       input logic [7:0] exp_rd);
        int n;
        bit ok;
        launch(a, r, w, aa, ad, rb);
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(2000, n, ok);
        check({name, "_done_seen"}, 32'(ok), 32'd1);
        check({name, "_latency"}, 32'(n), 32'(exp_qtr * CLK_DIV));
        check({name, "_nack"}, 32'(nack), 32'(exp_nack));
        check({name, "_rdata"}, 32'(rdata), 32'(exp_rd));
        check({name, "_busy_clr"}, 32'(busy), 32'd0);
        check_frames(name);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // Transaction-level reference: what a slave sees on the bus and what status results.
    task automatic ref_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic aa, input logic ad, input logic [7:0] rb,
                           output int qtr, output logic nk, output logic [7:0] rd);
        exp_q.push_back({a, r, ~aa});
        if (aa) exp_q.push_back({(r ? rb : w), (r | ~ad)});
        qtr = aa ? (1 + 9 + 9 + 1) * 4 : (1 + 9 + 1) * 4;
        nk  = !aa || (!r && !ad);
        rd  = (aa && r) ? rb : model_rdata;
    endtask

    typedef struct {
        logic [6:0] a;  logic r;  logic [7:0] w;  logic aa; logic ad; logic [7:0] rb;
        int qtr; logic nk; logic [7:0] rd;
        logic [7:0] b0; logic k0; logic [7:0] b1; logic k1; int nf;
    } vec_t;

    vec_t tv[6];

    initial begin
        int n, sc, dc, qtr;
        bit ok;
        logic nk;
        logic [7:0] rd, rw8, rb8;
        logic [6:0] ra;
        logic rr, raa, rad;

        tv[0] = '{7'h60, 1'b0, 8'hB8, 1'b1, 1'b1, 8'h00, 80, 1'b0, 8'h00, 8'hC0, 1'b0, 8'hB8, 1'b0, 2};
        tv[1] = '{7'h5F, 1'b1, 8'h00, 1'b1, 1'b1, 8'hBE, 80, 1'b0, 8'hBE, 8'hBF, 1'b0, 8'hBE, 1'b1, 2};
        tv[2] = '{7'h2A, 1'b0, 8'h55, 1'b0, 1'b1, 8'h00, 44, 1'b1, 8'hBE, 8'h54, 1'b1, 8'h00, 1'b0, 1};
        tv[3] = '{7'h11, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 80, 1'b1, 8'hBE, 8'h22, 1'b0, 8'h3C, 1'b1, 2};
        tv[4] = '{7'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 44, 1'b1, 8'hBE, 8'hFF, 1'b1, 8'h00, 1'b0, 1};
        tv[5] = '{7'h00, 1'b1, 8'h00, 1'b1, 1'b1, 8'h01, 80, 1'b0, 8'h01, 8'h01, 1'b0, 8'h01, 1'b1, 2};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        enb = 1'b1;
        @(negedge clk);

        // vector table
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({tv[i].b0, tv[i].k0});
            if (tv[i].nf == 2) exp_q.push_back({tv[i].b1, tv[i].k1});
            txn($sformatf("vec%0d", i), tv[i].a, tv[i].r, tv[i].w, tv[i].aa, tv[i].ad,
                tv[i].rb, tv[i].qtr, tv[i].nk, tv[i].rd);
        end
        model_rdata = 8'h01;

        // random transactions against the model
        for (int i = 0; i < 8; i++) begin
            ra  = 7'($urandom_range(0, 127));
            rr  = 1'($urandom_range(0, 1));
            rw8 = 8'($urandom_range(0, 255));
            raa = ($urandom_range(0, 3) != 0);
            rad = 1'($urandom_range(0, 1));
            rb8 = 8'($urandom_range(0, 255));
            ref_txn(ra, rr, rw8, raa, rad, rb8, qtr, nk, rd);
            txn($sformatf("rnd%0d", i), ra, rr, rw8, raa, rad, rb8, qtr, nk, rd);
            model_rdata = rd;
        end

        // START re-pulsed while busy with a different address
        dc = done_cnt;
        exp_q.push_back({7'h44, 1'b0, 1'b0});
        exp_q.push_back({8'h9A, 1'b0});
        launch(7'h44, 1'b0, 8'h9A, 1'b1, 1'b1, 8'h00);
        repeat (40) @(negedge clk);
        addr = 7'h0A; wdata = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, n, ok);
        check("busy_restart_done", 32'(ok), 32'd1);
        check("busy_restart_nack", 32'(nack), 32'd0);
        check_frames("busy_restart");
        repeat (100) @(negedge clk);
        @(posedge clk);
        check("busy_restart_one_done", 32'(done_cnt), 32'(dc + 1));
        check("busy_restart_idle", 32'(busy), 32'd0);

        // ENB low in idle: START ignored
        @(negedge clk);
        enb = 1'b0;
        dc = done_cnt;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("enb_low_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        check("enb_low_no_done", 32'(done_cnt), 32'(dc));
        @(negedge clk);
        enb = 1'b1;

        // START held high: back-to-back transactions
        dc = done_cnt;
        exp_q.push_back({7'h12, 1'b0, 1'b0});
        exp_q.push_back({8'h34, 1'b0});
        @(negedge clk);
        cfg_aa = 1'b1; cfg_ad = 1'b1;
        addr = 7'h12; rw = 1'b0; wdata = 8'h34; start = 1'b1;
        wait_done(2000, n, ok);
        check("held_done", 32'(ok), 32'd1);
        check("held_latency", 32'(n), 32'(80 * CLK_DIV + 1));
        check_frames("held1");
        exp_q.push_back({7'h12, 1'b0, 1'b0});
        exp_q.push_back({8'h34, 1'b0});
        @(negedge clk);
        check("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(2000, n, ok);
        check("held2_latency", 32'(n), 32'(80 * CLK_DIV));
        check_frames("held2");
        repeat (20) @(negedge clk);
        @(posedge clk);
        check("held_two_dones", 32'(done_cnt), 32'(dc + 2));

        // ENB dropped during data bit 3 of a read
        launch(7'h33, 1'b1, 8'h00, 1'b1, 1'b1, 8'h9F);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (bit_idx == 12) ok = 1'b1;
        end
        check("abort_reach_bit3", 32'(ok), 32'd1);
        sc = stop_cnt;
        enb = 1'b0;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 6 * CLK_DIV) begin
            @(posedge clk);
            n++;
            if (stop_cnt != sc) ok = 1'b1;
        end
        check("abort_stop_seen", 32'(ok), 32'd1);
        check("abort_stop_latency", 32'(n <= 3 * CLK_DIV + 1), 32'd1);
        ok = 1'b0;
        while (!ok && n < 10 * CLK_DIV) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        check("abort_done", 32'(ok), 32'd1);
        check("abort_done_window", 32'(n > 4 * CLK_DIV && n <= 5 * CLK_DIV), 32'd1);
        check("abort_nack", 32'(nack), 32'd1);
        check("abort_rdata_kept", 32'(rdata), 32'(model_rdata));
        enb = 1'b1;
        repeat (4) @(negedge clk);

        // asynchronous reset in the middle of the address byte
        launch(7'h2C, 1'b0, 8'hF0, 1'b1, 1'b1, 8'h00);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (bit_idx == 2 && !scl) ok = 1'b1;
        end
        check("rst_mid_reach", 32'(ok), 32'd1);
        dc = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_scl", 32'(scl), 32'd1);
        check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        @(posedge clk);
        check("rst_mid_no_done", 32'(done_cnt), 32'(dc));
        check("rst_mid_rdata", 32'(rdata), 32'd0);

        check("read_ack_slot_released", 32'(rd_ack_oe), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
